// File: rtl/ternary_pkg.sv
// Shared constants for the trit-serial ternary ALU: opcodes, trit codes and FSM states.
// Trit encoding {hi,lo}: 00=0, 01=1, 10=2, 11=illegal.
package ternary_pkg;

   typedef enum logic [1:0] {
      OP_MIN  = 2'b00,
      OP_MAX  = 2'b01,
      OP_CONS = 2'b10,
      OP_ANY  = 2'b11
   } op_e;

   localparam logic [1:0] T0   = 2'b00;
   localparam logic [1:0] T1   = 2'b01;
   localparam logic [1:0] T2   = 2'b10;
   localparam logic [1:0] TILL = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

   function automatic logic is_illegal(input logic [1:0] t);
      return t == TILL;
   endfunction

endpackage

// File: rtl/ternary_trit_alu.sv
// Combinational single-trit ALU: MIN, MAX, CONSENSUS and ANY selected by op.
module ternary_trit_alu
   import ternary_pkg::*;
(
   input  logic [1:0] op,
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic [1:0] z
);

   logic [1:0] t_min, t_max, t_cons, t_any;

   // Legal trit codes order numerically, so plain unsigned compare gives min/max.
   assign t_min  = (x < y) ? x : y;
   assign t_max  = (x > y) ? x : y;
   assign t_cons = (x == y) ? x : T1;

   always_comb begin
      // NOTE: every variable written here gets a default first so no latch is inferred.
      t_any = T1;
      if (x == y)       t_any = x;
      else if (x == T1) t_any = y;
      else if (y == T1) t_any = x;
   end

   always_comb begin
      z = t_min;
      unique case (op_e'(op))
         OP_MIN:  z = t_min;
         OP_MAX:  z = t_max;
         OP_CONS: z = t_cons;
         OP_ANY:  z = t_any;
         default: z = t_min;
      endcase
   end

endmodule

// File: rtl/ternary_serial_alu_ctrl.sv
// Trit-serial sequencer: captures two packed ternary words, feeds one trit per cycle LSB first
// through ternary_trit_alu, then holds the packed result. Optional macro: TERNARY_ILLEGAL_CHECK_EN.
module ternary_serial_alu_ctrl
   import ternary_pkg::*;
#(
   parameter int TRITS = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         op,
   input  logic [2*TRITS-1:0] a,
   input  logic [2*TRITS-1:0] b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*TRITS-1:0] result,
   output logic               err
);

   localparam int              W    = 2 * TRITS;
   localparam int              CW   = $clog2(TRITS + 1);
   localparam logic [CW-1:0]   LAST = CW'(TRITS - 1);

   state_e        state, state_nxt;
   logic [W-1:0]  a_sr, b_sr;
   logic [1:0]    op_q;
   logic [CW-1:0] cnt;
   logic [1:0]    alu_z, res_trit;
   logic          accept;

   ternary_trit_alu u_alu (
      .op (op_q),
      .x  (a_sr[1:0]),
      .y  (b_sr[1:0]),
      .z  (alu_z)
   );

`ifdef TERNARY_ILLEGAL_CHECK_EN
   logic trit_bad;
   assign trit_bad = is_illegal(a_sr[1:0]) || is_illegal(b_sr[1:0]);
   assign res_trit = trit_bad ? T1 : alu_z;
`else
   assign res_trit = alu_z;
`endif

   assign accept = in_valid && in_ready;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = S_RUN;
         end
         S_RUN:  if (cnt == LAST) state_nxt = S_DONE;
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         result <= '0;
         a_sr   <= '0;
         b_sr   <= '0;
         op_q   <= OP_MIN;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_sr <= a;
            b_sr <= b;
            op_q <= op;
            cnt  <= '0;
         end else if (state == S_RUN) begin
            a_sr   <= a_sr >> 2;
            b_sr   <= b_sr >> 2;
            // New trit enters at the MS end; after TRITS shifts trit 0 lands at bits [1:0].
            result <= W'({res_trit, result} >> 2);
            cnt    <= cnt + 1'b1;
         end
      end
   end

`ifdef TERNARY_ILLEGAL_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset)                           err <= 1'b0;
      else if (accept)                     err <= 1'b0;
      else if (state == S_RUN && trit_bad) err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ternary_serial_alu_ctrl.sv
// Self-checking bench for ternary_serial_alu_ctrl at TRITS=4 against a trit-level reference model.
module tb_ternary_serial_alu_ctrl;

   localparam int TRITS = 4;
   localparam int W     = 2 * TRITS;
   localparam int LAT   = TRITS + 1;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   op;
   logic [W-1:0] a, b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         err;

   int n_checks = 0;
   int n_fail   = 0;

   ternary_serial_alu_ctrl #(.TRITS(TRITS)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .err       (err)
   );

   always #5 clk = ~clk;

   function automatic int trit_fn(input int o, input int x, input int y);
      case (o)
         0: return (x < y) ? x : y;
         1: return (x > y) ? x : y;
         2: return (x == y) ? x : 1;
         default: begin
            if (x == y) return x;
            if (x == 1) return y;
            if (y == 1) return x;
            return 1;
         end
      endcase
   endfunction

   function automatic logic [W-1:0] model(input int o, input logic [W-1:0] wa, input logic [W-1:0] wb);
      logic [W-1:0] r;
      int x, y, z;
      r = '0;
      for (int i = 0; i < TRITS; i++) begin
         x = int'(wa[2*i +: 2]);
         y = int'(wb[2*i +: 2]);
         z = trit_fn(o, x, y);
`ifdef TERNARY_ILLEGAL_CHECK_EN
         if (x == 3 || y == 3) z = 1;
`endif
         r[2*i +: 2] = 2'(z);
      end
      return r;
   endfunction

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] w;
      for (int i = 0; i < TRITS; i++) w[2*i +: 2] = 2'($urandom_range(0, 2));
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one job from IDLE and waits (bounded) for out_valid; lat=-1 on timeout.
   task automatic do_job(input logic [1:0] o, input logic [W-1:0] wa, input logic [W-1:0] wb,
                         output logic [W-1:0] res, output logic e, output int lat);
      in_valid = 1'b1;
      op = o; a = wa; b = wb;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 50) begin
         tick();
         lat++;
      end
      if (!out_valid) lat = -1;
      res = result;
      e   = err;
   endtask

   task automatic release_job();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0;
      tick(); tick();
      reset = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h err=%b, want 1 0 00 0",
                  in_ready, out_valid, result, err);
      end
   endtask

   task automatic test_directed();
      logic [1:0]   ops [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic [W-1:0] as  [4] = '{8'h92, 8'h92, 8'h92, 8'h92};
      logic [W-1:0] bs  [4] = '{8'h1A, 8'h1A, 8'h1A, 8'h5A};
      logic [W-1:0] exp [4] = '{8'h12, 8'h9A, 8'h56, 8'h96};
      logic [W-1:0] res;
      logic e;
      int lat;
      for (int i = 0; i < 4; i++) begin
         do_job(ops[i], as[i], bs[i], res, e, lat);
         n_checks++;
         if (res !== exp[i] || lat != LAT || e !== 1'b0) begin
            n_fail++;
            $display("FAIL directed_%0d: result=%h lat=%0d err=%b, want %h lat=%0d err=0",
                     i, res, lat, e, exp[i], LAT);
         end
         release_job();
         n_checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL directed_release_%0d: in_ready=%b out_valid=%b, want 1 0",
                     i, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] ra, rb, res, exp;
      logic [1:0] o;
      logic e;
      int lat;
      for (int i = 0; i < 24; i++) begin
         ra = rand_word(); rb = rand_word(); o = 2'($urandom_range(0, 3));
         exp = model(int'(o), ra, rb);
         do_job(o, ra, rb, res, e, lat);
         n_checks++;
         if (res !== exp || lat != LAT || e !== 1'b0) begin
            n_fail++;
            $display("FAIL random_%0d op=%0d a=%h b=%h: result=%h lat=%0d err=%b, want %h lat=%0d err=0",
                     i, o, ra, rb, res, lat, e, exp, LAT);
         end
         release_job();
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] res, exp;
      logic e;
      int lat;
      int bad = 0;
      exp = model(1, 8'h92, 8'h1A);
      do_job(2'b01, 8'h92, 8'h1A, res, e, lat);
      n_checks++;
      if (res !== exp || lat != LAT) begin
         n_fail++;
         $display("FAIL bp_result: result=%h lat=%0d, want %h lat=%0d", res, lat, exp, LAT);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid !== 1'b1 || result !== exp || in_ready !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
      end
      release_job();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a1, b1, a2, b2, exp1, exp2;
      int lat;
      int busy_ready = 0;
      a1 = rand_word(); b1 = rand_word(); a2 = rand_word(); b2 = rand_word();
      exp1 = model(3, a1, b1);
      exp2 = model(0, a2, b2);
      in_valid = 1'b1; op = 2'b11; a = a1; b = b1;
      tick();
      op = 2'b00; a = a2; b = b2;
      lat = 1;
      while (!out_valid && lat < 50) begin
         if (in_ready !== 1'b0) busy_ready++;
         tick();
         lat++;
      end
      n_checks++;
      if (result !== exp1 || lat != LAT || busy_ready != 0) begin
         n_fail++;
         $display("FAIL b2b_first: result=%h lat=%0d busy_ready=%0d, want %h lat=%0d 0",
                  result, lat, busy_ready, exp1, LAT);
      end
      release_job();
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_idle: in_ready=%b, want 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_accept: in_ready=%b, want 0", in_ready);
      end
      lat = 1;
      while (!out_valid && lat < 50) begin
         tick();
         lat++;
      end
      n_checks++;
      if (result !== exp2 || lat != LAT) begin
         n_fail++;
         $display("FAIL b2b_second: result=%h lat=%0d, want %h lat=%0d", result, lat, exp2, LAT);
      end
      release_job();
   endtask

   task automatic test_reset_mid_run();
      int spurious = 0;
      in_valid = 1'b1; op = 2'b01; a = 8'h92; b = 8'h1A;
      tick();
      in_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_run: out_valid=%b in_ready=%b result=%h, want 0 1 00",
                  out_valid, in_ready, result);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid !== 1'b0) spurious++;
      end
      n_checks++;
      if (spurious != 0) begin
         n_fail++;
         $display("FAIL reset_no_spurious: %0d cycles with out_valid, want 0", spurious);
      end
   endtask

`ifdef TERNARY_ILLEGAL_CHECK_EN
   task automatic test_illegal();
      logic [W-1:0] res;
      logic e;
      int lat;
      do_job(2'b00, 8'h03, 8'h00, res, e, lat);
      n_checks++;
      if (e !== 1'b1 || res !== 8'h01 || lat != LAT) begin
         n_fail++;
         $display("FAIL illegal_job: err=%b result=%h lat=%0d, want 1 01 %0d", e, res, lat, LAT);
      end
      release_job();
      do_job(2'b01, 8'h92, 8'h1A, res, e, lat);
      n_checks++;
      if (e !== 1'b0 || res !== 8'h9A) begin
         n_fail++;
         $display("FAIL illegal_clear: err=%b result=%h, want 0 9a", e, res);
      end
      release_job();
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_run();
`ifdef TERNARY_ILLEGAL_CHECK_EN
      test_illegal();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
